hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, mul/div freeze with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_rs1_re,
  input  logic        id_rs2_re,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_rd_we,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  input  logic        ex_md_done,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        md_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [6:0]  OpLoad = 7'b0000011;
  localparam logic [15:0] WdLast = 16'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e      state_q, state_d;
  logic [15:0] wd_cnt_q, wd_cnt_d, wd_cnt_inc;
  logic        md_timeout_q, md_timeout_d;
  logic        lu;

  assign lu = (ex_opcode == OpLoad) && ex_rd_we && (ex_rd_addr != 5'd0) &&
              ((id_rs1_re && (id_rs1_addr == ex_rd_addr)) ||
               (id_rs2_re && (id_rs2_addr == ex_rd_addr)));

  assign wd_cnt_inc = wd_cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    wd_cnt_d     = wd_cnt_q;
    md_timeout_d = md_timeout_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    // Outputs are forced low for the whole reset cycle.
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_md_start && !ex_md_done) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            state_d     = StMdWait;
            wd_cnt_d    = 16'd0;
          end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        StMdWait: begin
          if (ex_md_done) begin
            state_d = StRun;
          end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            wd_cnt_d    = wd_cnt_inc;
            // Start cycle plus MD_TIMEOUT-1 wait cycles bounds the freeze.
            if (wd_cnt_inc == WdLast) begin
              md_timeout_d = 1'b1;
              state_d      = StRun;
            end
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      wd_cnt_q     <= 16'd0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (id_ex_flush && (flush_events_q != 32'hFFFF_FFFF)) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_rs1_re, id_rs2_re;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [6:0]  ex_opcode;
  logic        ex_rd_we;
  logic [4:0]  ex_rd_addr;
  logic        ex_redirect, ex_md_start, ex_md_done;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, md_timeout;
  logic [31:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_re    (id_rs1_re),
    .id_rs2_re    (id_rs2_re),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .ex_opcode    (ex_opcode),
    .ex_rd_we     (ex_rd_we),
    .ex_rd_addr   (ex_rd_addr),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .ex_md_done   (ex_md_done),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .md_timeout   (md_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  // Model state: busy with a mul/div op, and stall cycles spent on it so far.
  bit          m_busy = 0;
  int          m_elapsed = 0;
  bit          m_tmo = 0;
  logic [31:0] m_stall = 0, m_flush = 0;

  function automatic logic [4:0] dut_outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush};
  endfunction

  // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}.
  function automatic logic [4:0] exp_outs();
    bit hit;
    hit = (ex_opcode == 7'd3) && ex_rd_we && (ex_rd_addr != 0) &&
          ((id_rs1_re && id_rs1_addr == ex_rd_addr) || (id_rs2_re && id_rs2_addr == ex_rd_addr));
    if (rst) return 5'b00000;
    if (m_busy) return ex_md_done ? 5'b00000 : 5'b11010;
    if (ex_redirect) return 5'b00101;
    if (ex_md_start && !ex_md_done) return 5'b11010;
    if (hit) return 5'b11001;
    return 5'b00000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [4:0] e;
    e = exp_outs();
    if (rst) begin
      m_busy = 0; m_elapsed = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (e[0] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (!m_busy) begin
        if (!ex_redirect && ex_md_start && !ex_md_done) begin
          m_busy = 1; m_elapsed = 1;
        end
      end else if (ex_md_done) begin
        m_busy = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= TO) begin m_busy = 0; m_tmo = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("outs", {27'd0, dut_outs()}, {27'd0, exp_outs()});
      check("md_timeout", {31'd0, md_timeout}, {31'd0, m_tmo});
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_events", flush_events, m_flush);
`else
      check("stall_cycles", stall_cycles, 32'd0);
      check("flush_events", flush_events, 32'd0);
`endif
    end
  end

  task automatic idle();
    id_rs1_re = 0; id_rs2_re = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    ex_opcode = 7'h13; ex_rd_we = 0; ex_rd_addr = 0;
    ex_redirect = 0; ex_md_start = 0; ex_md_done = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_opcode = 7'b0000011; ex_rd_we = 1; ex_rd_addr = rd;
    id_rs2_re = 1; id_rs2_addr = 5;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); next(); rst = 0;
  endtask

  initial begin
    int n;
    idle();
    next();
    chk_en = 1;
    @(negedge clk);
    check("reset_outs", {27'd0, dut_outs()}, 32'd0);
    next(); rst = 0;
    @(negedge clk);
    check("reset_tmo", {31'd0, md_timeout}, 32'd0);
    check("reset_stall_cnt", stall_cycles, 32'd0);

    // Load-use, one cycle then bubble.
    set_lu(5); @(negedge clk);
    check("lu_outs", {27'd0, dut_outs()}, 32'b11001);
    next(); idle(); @(negedge clk);
    check("lu_bubble", {27'd0, dut_outs()}, 32'd0);
    next(); set_lu(0); @(negedge clk);
    check("lu_x0", {27'd0, dut_outs()}, 32'd0);
    next(); set_lu(5); ex_redirect = 1; @(negedge clk);
    check("redirect_prio", {27'd0, dut_outs()}, 32'b00101);

    // Counters: reset, 1 load-use, 4-cycle mul/div.
    next(); do_reset();
    set_lu(5); next(); idle();
    next();
    ex_md_start = 1; n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); n += int'(pc_stall);
      next(); ex_md_start = 0;
    end
    ex_md_done = 1; @(negedge clk);
    check("md_stall_len", n, 4);
    check("md_done_outs", {27'd0, dut_outs()}, 32'd0);
    next(); idle(); set_lu(5); @(negedge clk);
    check("md_back_run", {27'd0, dut_outs()}, 32'b11001);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", stall_cycles, 32'd5);
    check("perf_flush", flush_events, 32'd1);
`else
    check("perf_stall_off", stall_cycles, 32'd0);
    check("perf_flush_off", flush_events, 32'd0);
`endif
    next(); idle(); ex_md_start = 1; ex_md_done = 1; @(negedge clk);
    check("md_single", {27'd0, dut_outs()}, 32'd0);

    // Watchdog: never done.
    next(); idle(); ex_md_start = 1; n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); n += int'(pc_stall);
      next(); ex_md_start = 0;
    end
    @(negedge clk);
    check("wd_stalls", n, TO);
    check("wd_tmo", {31'd0, md_timeout}, 32'd1);
    next(); set_lu(5); @(negedge clk);
    check("wd_lu", {27'd0, dut_outs()}, 32'b11001);
    check("wd_tmo_held", {31'd0, md_timeout}, 32'd1);

    // Reset on the 3rd wait cycle.
    next(); idle(); ex_md_start = 1; next(); ex_md_start = 0;
    next(); next(); rst = 1; @(negedge clk);
    check("rst_mid_outs", {27'd0, dut_outs()}, 32'd0);
    next(); rst = 0; @(negedge clk);
    check("rst_mid_after", {27'd0, dut_outs()}, 32'd0);
    check("rst_mid_tmo", {31'd0, md_timeout}, 32'd0);
    next(); set_lu(5); @(negedge clk);
    check("rst_mid_lu", {27'd0, dut_outs()}, 32'b11001);
    next(); idle();

    // Randomized traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1_re   = 1'($urandom_range(0, 1));
      id_rs2_re   = 1'($urandom_range(0, 1));
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_opcode   = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b0110011;
      ex_rd_we    = ($urandom_range(0, 3) != 0);
      ex_rd_addr  = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_md_start = ($urandom_range(0, 9) == 0);
      ex_md_done  = ($urandom_range(0, 11) == 0);
      next();
    end
    idle();
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
